// File: rtl/axis_arb_pkg.sv
// Shared types for the AXI-Stream egress schedulers: arbiter state encoding
// and the all-ones tkeep helper macro.
`ifndef AXIS_ARB_PKG_SV
`define AXIS_ARB_PKG_SV

`define AXIS_ARB_TKEEP_ONES(w) {(w){1'b1}}

package axis_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        ARBITRATE = 3'b010,
        STREAM    = 3'b100
    } arb_state_t;

endpackage

`endif

// File: rtl/axis_frame_arbiter_rr_grant.sv
// rr_grant: combinational rotate-priority encoder. Returns the first set request
// at or after the pointer, wrapping past NUM_CHANNELS-1 back to channel 0.
module rr_grant #(
    parameter int NUM_CHANNELS = 4,
    parameter int CH_BITS      = 2
) (
    input  logic [NUM_CHANNELS-1:0] request,
    input  logic [CH_BITS-1:0]      pointer,
    output logic [CH_BITS-1:0]      grant,
    output logic                    grant_valid
);

    logic [CH_BITS:0]   sum_s;
    logic [CH_BITS-1:0] idx_s;
    logic               hit_s;

    // Scan channels in rotated order; the first hit wins and later hits are masked.
    always_comb begin
        grant       = {CH_BITS{1'b0}};
        grant_valid = 1'b0;
        sum_s       = {(CH_BITS+1){1'b0}};
        idx_s       = {CH_BITS{1'b0}};
        hit_s       = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            sum_s = {1'b0, pointer} + (CH_BITS+1)'(i);
            sum_s = (sum_s >= (CH_BITS+1)'(NUM_CHANNELS)) ?
                    sum_s - (CH_BITS+1)'(NUM_CHANNELS) : sum_s;
            idx_s       = sum_s[CH_BITS-1:0];
            hit_s       = !grant_valid && request[idx_s];
            grant       = hit_s ? idx_s : grant;
            grant_valid = grant_valid | hit_s;
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-atomic round-robin scheduler from per-flow FWFT FIFOs onto one AXI-Stream egress.
// Optional macro AXIS_FRAME_ARB_TDEST_EN adds tdest_out carrying the source channel.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_SIZE    = 512,
    parameter int NUM_CHANNELS = 4,
    parameter int CH_BITS      = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           fifo_empty,
    input  logic [NUM_CHANNELS-1:0]           fifo_frame_ready,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] fifo_data_out,
    input  logic [NUM_CHANNELS-1:0]           fifo_last_out,
    output logic [NUM_CHANNELS-1:0]           fifo_read_enable,
    input  logic                              tready_in,
    output logic                              tvalid_out,
    output logic [DATA_SIZE-1:0]              tdata_out,
    output logic                              tlast_out,
    output logic [DATA_SIZE/8-1:0]            tkeep_out,
    output logic [CH_BITS-1:0]                grant_out,
    output logic                              busy_out
`ifdef AXIS_FRAME_ARB_TDEST_EN
    ,
    output logic [CH_BITS-1:0]                tdest_out
`endif
);

    arb_state_t           state_r;
    arb_state_t           state_next_s;
    logic [CH_BITS-1:0]   rr_ptr_r;
    logic [CH_BITS-1:0]   arb_grant_s;
    logic                 arb_valid_s;
    logic [DATA_SIZE-1:0] head_data_s;
    logic                 head_last_s;
    logic                 head_empty_s;
    logic                 pop_s;

    rr_grant #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CH_BITS     (CH_BITS)
    ) u_rr_grant (
        .request    (fifo_frame_ready),
        .pointer    (rr_ptr_r),
        .grant      (arb_grant_s),
        .grant_valid(arb_valid_s)
    );

    // Select the granted channel's head word and compute the pop strobe.
    always_comb begin
        head_data_s      = {DATA_SIZE{1'b0}};
        fifo_read_enable = {NUM_CHANNELS{1'b0}};
        head_last_s      = fifo_last_out[grant_out];
        head_empty_s     = fifo_empty[grant_out];
        pop_s            = (state_r == STREAM) && !head_empty_s && (!tvalid_out || tready_in);
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            head_data_s = (grant_out == CH_BITS'(i)) ?
                          fifo_data_out[i*DATA_SIZE +: DATA_SIZE] : head_data_s;
            fifo_read_enable[i] = pop_s && (grant_out == CH_BITS'(i));
        end
    end

    // Next-state logic; a withdrawn request during ARBITRATE falls back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:      state_next_s = (|fifo_frame_ready) ? ARBITRATE : IDLE;
            ARBITRATE: state_next_s = arb_valid_s ? STREAM : IDLE;
            STREAM:    state_next_s = (pop_s && head_last_s) ? ARBITRATE : STREAM;
            default:   state_next_s = IDLE;
        endcase
    end

    // Control registers: state, grant, round-robin pointer and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_out <= {CH_BITS{1'b0}};
            rr_ptr_r  <= {CH_BITS{1'b0}};
            busy_out  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_out <= (state_next_s != IDLE);
            if (state_r == ARBITRATE && arb_valid_s) begin
                grant_out <= arb_grant_s;
            end
            // The pointer moves past the granted channel only once its frame is complete.
            if (pop_s && head_last_s) begin
                rr_ptr_r <= (grant_out == CH_BITS'(NUM_CHANNELS-1)) ?
                            {CH_BITS{1'b0}} : grant_out + CH_BITS'(1);
            end
        end
    end

    // One-word output register; holds steady while the sink back-pressures.
    always_ff @(posedge clock) begin
        if (reset) begin
            tvalid_out <= 1'b0;
            tdata_out  <= {DATA_SIZE{1'b0}};
            tlast_out  <= 1'b0;
            tkeep_out  <= {(DATA_SIZE/8){1'b0}};
`ifdef AXIS_FRAME_ARB_TDEST_EN
            tdest_out  <= {CH_BITS{1'b0}};
`endif
        end else if (pop_s) begin
            tvalid_out <= 1'b1;
            tdata_out  <= head_data_s;
            tlast_out  <= head_last_s;
            tkeep_out  <= `AXIS_ARB_TKEEP_ONES(DATA_SIZE/8);
`ifdef AXIS_FRAME_ARB_TDEST_EN
            tdest_out  <= grant_out;
`endif
        end else if (tready_in) begin
            tvalid_out <= 1'b0;
            tkeep_out  <= {(DATA_SIZE/8){1'b0}};
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Self-checking bench for axis_frame_arbiter: FIFO models feed the arbiter, and a
// scoreboard queue holds the words expected on the egress in order.
module tb_axis_frame_arbiter;

    localparam int DS = 512;
    localparam int NC = 4;
    localparam int CB = 2;
    localparam int KW = DS / 8;

    logic             clock;
    logic             reset;
    logic [NC-1:0]    fifo_empty;
    logic [NC-1:0]    fifo_frame_ready;
    logic [NC*DS-1:0] fifo_data_out;
    logic [NC-1:0]    fifo_last_out;
    logic [NC-1:0]    fifo_read_enable;
    logic             tready_in;
    logic             tvalid_out;
    logic [DS-1:0]    tdata_out;
    logic             tlast_out;
    logic [KW-1:0]    tkeep_out;
    logic [CB-1:0]    grant_out;
    logic             busy_out;
`ifdef AXIS_FRAME_ARB_TDEST_EN
    logic [CB-1:0]    tdest_out;
`endif

    axis_frame_arbiter #(.DATA_SIZE(DS), .NUM_CHANNELS(NC), .CH_BITS(CB)) dut (
        .clock           (clock),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_frame_ready(fifo_frame_ready),
        .fifo_data_out   (fifo_data_out),
        .fifo_last_out   (fifo_last_out),
        .fifo_read_enable(fifo_read_enable),
        .tready_in       (tready_in),
        .tvalid_out      (tvalid_out),
        .tdata_out       (tdata_out),
        .tlast_out       (tlast_out),
        .tkeep_out       (tkeep_out),
        .grant_out       (grant_out),
        .busy_out        (busy_out)
`ifdef AXIS_FRAME_ARB_TDEST_EN
        ,
        .tdest_out       (tdest_out)
`endif
    );

    typedef struct { logic [DS-1:0] data; logic last; } fw_t;
    typedef struct { logic [DS-1:0] data; logic last; int ch; bit first; } ex_t;
    typedef struct { int grp; int ch; int len; int pos; } vec_t;

    fw_t           fq[NC][$];
    ex_t           exq[$];
    int            hs_cyc[$];
    bit            stall[NC];
    int            popped[NC];
    logic [NC-1:0] last_rd;
    int            cyc;
    int            n_chk;
    int            n_pass;
    vec_t          tbl[6];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [DS-1:0] mkw(input int c, input int f, input int i);
        logic [31:0] w;
        w = {8'(f), 8'(c), 8'(i), 8'hA5};
        return {(DS/32){w}};
    endfunction

    task automatic chk(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load_frame(input int c, input int len, input int f);
        fw_t e;
        for (int i = 0; i < len; i++) begin
            e.data = mkw(c, f, i);
            e.last = (i == len - 1);
            fq[c].push_back(e);
        end
    endtask

    task automatic push_exp(input int c, input int len, input int f);
        ex_t e;
        for (int i = 0; i < len; i++) begin
            e.data  = mkw(c, f, i);
            e.last  = (i == len - 1);
            e.ch    = c;
            e.first = (i == 0);
            exq.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        bit has_frame;
        for (int c = 0; c < NC; c++) begin
            has_frame = 1'b0;
            for (int k = 0; k < fq[c].size(); k++) begin
                if (fq[c][k].last) has_frame = 1'b1;
            end
            fifo_frame_ready[c] = has_frame;
            fifo_empty[c]       = stall[c] || (fq[c].size() == 0);
            if (fq[c].size() > 0) begin
                fifo_data_out[c*DS +: DS] = fq[c][0].data;
                fifo_last_out[c]          = fq[c][0].last;
            end else begin
                fifo_data_out[c*DS +: DS] = '0;
                fifo_last_out[c]          = 1'b0;
            end
        end
    endtask

    task automatic check_out();
        ex_t e;
        if (exq.size() == 0) begin
            chki("unexpected_word", 1, 0);
        end else begin
            e = exq.pop_front();
            chk("tdata", tdata_out, e.data);
            chki("tlast", int'(tlast_out), int'(e.last));
            chk("tkeep", DS'(tkeep_out), DS'({KW{1'b1}}));
            if (e.first) chki("grant", int'(grant_out), e.ch);
`ifdef AXIS_FRAME_ARB_TDEST_EN
            chki("tdest", int'(tdest_out), e.ch);
`endif
        end
    endtask

    // One clock: drive FIFO model, sample before the edge, advance, apply pops.
    task automatic step();
        drive_inputs();
        #1;
        last_rd = fifo_read_enable;
        if (tvalid_out && tready_in) begin
            hs_cyc.push_back(cyc);
            check_out();
        end
        if ($countones(last_rd) > 1) chki("read_onehot", $countones(last_rd), 1);
        @(posedge clock);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++) begin
            if (last_rd[c]) begin
                chki("read_nonempty", int'(fq[c].size() > 0), 1);
                if (fq[c].size() > 0) begin
                    void'(fq[c].pop_front());
                    popped[c]++;
                end
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exq.size() != 0 || tvalid_out === 1'b1) && n < budget) begin
            step();
            n++;
        end
        chki({name, "_drained"}, exq.size(), 0);
        repeat (2) step();
        chki({name, "_idle"}, int'(busy_out), 0);
    endtask

    initial begin
        logic [DS-1:0] hold_d;
        logic          hold_l;
        int            n;

        n_chk = 0; n_pass = 0; cyc = 0;
        reset = 1'b1; tready_in = 1'b1;
        fifo_empty = '1; fifo_frame_ready = '0; fifo_data_out = '0; fifo_last_out = '0;
        for (int c = 0; c < NC; c++) begin stall[c] = 1'b0; popped[c] = 0; end

        // Frame table: {group, channel, length, egress position within group}.
        tbl[0] = '{1, 0, 3, 0};
        tbl[1] = '{1, 2, 2, 1};
        tbl[2] = '{2, 0, 1, 1};
        tbl[3] = '{2, 1, 3, 2};
        tbl[4] = '{2, 2, 2, 3};
        tbl[5] = '{2, 3, 2, 0};

        @(posedge clock); #1;
        step(); step();
        chki("rst_tvalid", int'(tvalid_out), 0);
        chki("rst_tlast", int'(tlast_out), 0);
        chk("rst_tdata", tdata_out, '0);
        chki("rst_tkeep", int'(tkeep_out != '0), 0);
        chki("rst_grant", int'(grant_out), 0);
        chki("rst_busy", int'(busy_out), 0);
        chki("rst_rd", int'(fifo_read_enable), 0);
        reset = 1'b0;

        // Group 1: ch0 + ch2 from pointer 0; group 2: all four from pointer 3.
        for (int g = 1; g <= 2; g++) begin
            hs_cyc.delete();
            for (int k = 0; k < 6; k++) begin
                if (tbl[k].grp == g) load_frame(tbl[k].ch, tbl[k].len, k + 1);
            end
            for (int p = 0; p < NC; p++) begin
                for (int k = 0; k < 6; k++) begin
                    if (tbl[k].grp == g && tbl[k].pos == p) push_exp(tbl[k].ch, tbl[k].len, k + 1);
                end
            end
            drain((g == 1) ? "grp1" : "grp2", 200);
            if (g == 1) begin
                chki("grp1_words", hs_cyc.size(), 5);
                if (hs_cyc.size() == 5) begin
                    chki("grp1_throughput", hs_cyc[1] - hs_cyc[0], 1);
                    chki("grp1_frame_gap", hs_cyc[3] - hs_cyc[2], 2);
                end
            end else begin
                chki("grp2_words", hs_cyc.size(), 8);
            end
        end

        // Back-pressure mid-frame on ch1.
        hs_cyc.delete();
        load_frame(1, 4, 20); push_exp(1, 4, 20);
        n = 0;
        while (hs_cyc.size() < 2 && n < 50) begin step(); n++; end
        chki("stall_reached", hs_cyc.size(), 2);
        chk("stall_word", tdata_out, mkw(1, 20, 2));
        chki("stall_valid", int'(tvalid_out), 1);
        hold_d = tdata_out; hold_l = tlast_out;
        tready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_tdata", tdata_out, hold_d);
            chki("stall_tlast", int'(tlast_out), int'(hold_l));
            chki("stall_tvalid", int'(tvalid_out), 1);
            chki("stall_rd", int'(last_rd), 0);
        end
        tready_in = 1'b1;
        drain("stall", 100);

        // Underrun on ch1 after two words while ch0 has a frame waiting.
        popped[1] = 0;
        load_frame(1, 4, 30); push_exp(1, 4, 30);
        n = 0;
        while (popped[1] < 2 && n < 50) begin step(); n++; end
        chki("underrun_reached", popped[1], 2);
        stall[1] = 1'b1;
        load_frame(0, 2, 31); push_exp(0, 2, 31);
        for (int i = 0; i < 5; i++) begin
            step();
            chki("underrun_tvalid", int'(tvalid_out), 0);
            chki("underrun_rd", int'(last_rd), 0);
            chki("underrun_grant", int'(grant_out), 1);
        end
        chki("underrun_busy", int'(busy_out), 1);
        stall[1] = 1'b0;
        drain("underrun", 100);

        // Reset in the middle of a ch2 frame.
        popped[2] = 0;
        load_frame(2, 6, 40); push_exp(2, 6, 40);
        n = 0;
        while (popped[2] < 2 && n < 50) begin step(); n++; end
        chki("midrst_reached", popped[2], 2);
        reset = 1'b1;
        step();
        chki("midrst_tvalid", int'(tvalid_out), 0);
        chki("midrst_rd", int'(fifo_read_enable), 0);
        chki("midrst_grant", int'(grant_out), 0);
        chki("midrst_busy", int'(busy_out), 0);
        reset = 1'b0;
        for (int c = 0; c < NC; c++) fq[c].delete();
        exq.delete();
        step();

        // Back-to-back single-word frames on ch0 then ch1.
        hs_cyc.delete();
        load_frame(0, 1, 50); load_frame(1, 1, 51);
        push_exp(0, 1, 50); push_exp(1, 1, 51);
        drain("single", 100);
        chki("single_words", hs_cyc.size(), 2);
        if (hs_cyc.size() == 2) chki("single_gap", hs_cyc[1] - hs_cyc[0], 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
